// File: rtl/regwrite_queue.sv
// rtl/regwrite_queue.sv - in-order register-write buffer feeding the register-select demux
// Optionally merges a request into the tail entry when it targets the same register.
module regwrite_queue #(
  parameter int dw       = 8,
  parameter int depth    = 4,
  parameter int coalesce = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_sel,
  input  logic [dw-1:0]              in_data,
  output logic                       out_valid,
  output logic [3:0]                 out_sel,
  output logic [dw-1:0]              out_data,
  input  logic                       out_ack,
  output logic [$clog2(depth):0]     count,
  output logic                       overflow
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [3:0]    sel_mem_q  [depth];
  logic [dw-1:0] data_mem_q [depth];

  logic [aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [cw-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push, pop, hit;
  logic [aw-1:0] tail_idx, wr_idx;

  assign in_ready  = (count_q != cw'(depth));
  assign out_valid = (count_q != '0);
  assign out_sel   = out_valid ? sel_mem_q[rd_ptr_q]  : 4'd0;
  assign out_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ack;
  assign tail_idx = wr_ptr_q - aw'(1);

  // A single-entry queue that is being drained cannot absorb a merge: the tail leaves this cycle.
  assign hit = (coalesce != 0) && push && (count_q != '0) &&
               (sel_mem_q[tail_idx] == in_sel) &&
               !((count_q == cw'(1)) && pop);

  assign wr_idx = hit ? tail_idx : wr_ptr_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push && !hit) begin
      wr_ptr_d = wr_ptr_q + aw'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + aw'(1);
    end
    count_d = count_q + cw'(push && !hit) - cw'(pop);
    if (in_valid && !in_ready) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; out_* are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      sel_mem_q[wr_idx]  <= in_sel;
      data_mem_q[wr_idx] <= in_data;
    end
  end

endmodule

// File: tb/tb_regwrite_queue.sv
// tb/tb_regwrite_queue.sv - directed self-checking bench for regwrite_queue
module tb_regwrite_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_sel;
  logic [7:0] in_data;
  logic       out_ack;

  logic       c_in_ready, c_out_valid, c_overflow;
  logic [3:0] c_out_sel;
  logic [7:0] c_out_data;
  logic [2:0] c_count;

  logic       n_in_ready, n_out_valid, n_overflow;
  logic [3:0] n_out_sel;
  logic [7:0] n_out_data;
  logic [2:0] n_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  regwrite_queue #(.dw(8), .depth(4), .coalesce(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(c_out_valid),
    .out_sel(c_out_sel), .out_data(c_out_data), .out_ack(out_ack),
    .count(c_count), .overflow(c_overflow)
  );

  regwrite_queue #(.dw(8), .depth(4), .coalesce(0)) dut_n (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(n_out_valid),
    .out_sel(n_out_sel), .out_data(n_out_data), .out_ack(out_ack),
    .count(n_count), .overflow(n_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_sel = 4'h3; in_data = 8'h33; out_ack = 1'b1;
    #1;
    tick();
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ack = 1'b0;
    check("rst_out_valid", c_out_valid, 0);
    check("rst_out_sel",   c_out_sel,   0);
    check("rst_out_data",  c_out_data,  0);
    check("rst_in_ready",  c_in_ready,  1);
    check("rst_count",     c_count,     0);
    check("rst_overflow",  c_overflow,  0);
    check("rst_count_nc",  n_count,     0);

    // in-order drain
    push(4'h2, 8'hA5);
    check("lat_valid", n_out_valid, 1);
    check("lat_sel",   n_out_sel,   4'h2);
    push(4'h5, 8'h3C);
    push(4'hF, 8'hFF);
    check("drain_count", n_count,    3);
    check("drain_sel0",  n_out_sel,  4'h2);
    check("drain_data0", n_out_data, 8'hA5);
    out_ack = 1'b1;
    tick();
    check("drain_sel1",  n_out_sel,  4'h5);
    check("drain_data1", n_out_data, 8'h3C);
    tick();
    check("drain_sel2",  n_out_sel,  4'hF);
    check("drain_data2", n_out_data, 8'hFF);
    tick();
    out_ack = 1'b0;
    check("drain_empty_valid", n_out_valid, 0);
    check("drain_empty_sel",   n_out_sel,   0);
    check("drain_empty_data",  n_out_data,  0);
    check("drain_empty_cnt_c", c_count,     0);

    // full and overflow
    for (int i = 1; i <= 4; i++) push(4'(i), 8'(i));
    check("full_in_ready", c_in_ready, 0);
    check("full_count",    c_count,    4);
    check("full_ovf_pre",  c_overflow, 0);
    push(4'h4, 8'h05);
    check("ovf_flag",      c_overflow, 1);
    check("ovf_count",     c_count,    4);
    check("ovf_flag_nc",   n_overflow, 1);
    out_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("full_drain_data", c_out_data, 32'(i));
      check("full_drain_sel",  c_out_sel,  32'(i));
      tick();
    end
    out_ack = 1'b0;
    check("full_drain_empty", c_out_valid, 0);
    check("ovf_sticky",       c_overflow,  1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ovf_cleared", c_overflow, 0);

    // coalescing
    push(4'h7, 8'h11);
    push(4'h7, 8'h22);
    check("merge_count",   c_count,    1);
    check("merge_sel",     c_out_sel,  4'h7);
    check("merge_data",    c_out_data, 8'h22);
    check("nomerge_count", n_count,    2);
    check("nomerge_data",  n_out_data, 8'h11);
    push(4'h9, 8'h99);
    check("merge2_count", c_count, 2);
    out_ack = 1'b1;
    push(4'h9, 8'hAA);
    check("merge_pop_count", c_count,    1);
    check("merge_pop_sel",   c_out_sel,  4'h9);
    check("merge_pop_data",  c_out_data, 8'hAA);
    check("nomerge_pop_cnt", n_count,    3);
    push(4'h9, 8'hBB);
    check("tailpop_count", c_count,    1);
    check("tailpop_sel",   c_out_sel,  4'h9);
    check("tailpop_data",  c_out_data, 8'hBB);
    for (int i = 0; i < 4; i++) tick();
    out_ack = 1'b0;
    check("merge_drained_c", c_count, 0);
    check("merge_drained_n", n_count, 0);

    // wrap-around streaming at count 2
    push(4'h0, 8'h10);
    push(4'h1, 8'h11);
    out_ack = 1'b1;
    for (int i = 2; i < 12; i++) begin
      check("stream_sel",  c_out_sel,  32'(i - 2));
      check("stream_data", c_out_data, 32'(8'h10 + i - 2));
      push(4'(i), 8'(8'h10 + i));
      check("stream_count", c_count, 2);
    end
    out_ack = 1'b0;
    check("stream_overflow", c_overflow, 0);
    check("stream_head",     c_out_sel,  4'hA);

    // reset mid-operation
    push(4'hC, 8'h1C);
    check("mid_count", c_count, 3);
    in_valid = 1'b1; in_sel = 4'hD; in_data = 8'h1D; out_ack = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ack = 1'b0;
    check("mid_rst_count",    c_count,     0);
    check("mid_rst_valid",    c_out_valid, 0);
    check("mid_rst_ready",    c_in_ready,  1);
    check("mid_rst_overflow", c_overflow,  0);
    push(4'h6, 8'h66);
    check("post_rst_valid", c_out_valid, 1);
    check("post_rst_sel",   c_out_sel,   4'h6);
    check("post_rst_data",  c_out_data,  8'h66);
    check("post_rst_count", c_count,     1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
